cic_decimator: RTL and testbench

//  Complex (I/Q) N-stage CIC decimator placed directly after quadrature_mixer.

---
 rtl/cic_decimator.sv | 153 +++++++++++++++
 tb/tb_cic_decimator.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator.sv
// -----------------------------------------------------------------------------
// cic_decimator
//   Complex (I/Q) N-stage CIC decimator with runtime power-of-two rate
//   R = 2^dec_log2 (clamped to RMAX_LOG2). The CIC gain R^N = 2^(N*dec_log2)
//   is removed exactly by an arithmetic right shift, so the DC gain is 1.
//   Result is saturated to DSZ bits and presented with a one-cycle out_valid.
//
//   Build option: define CIC_ROUND_EN to round half-up before the gain shift.
//   Without it the shift truncates toward minus infinity.
//
// Ports
//   clk        clock
//   reset      synchronous, active-low reset
//   dec_log2   decimation log2 (values above RMAX_LOG2 are clamped)
//   in_valid   input sample strobe (may be high every cycle)
//   in_i/in_q  signed DSZ-bit input sample
//   out_valid  one-cycle pulse per decimated output
//   out_i/out_q signed DSZ-bit output, held between strobes
// -----------------------------------------------------------------------------
module cic_decimator #(
  parameter int DSZ       = 16,
  parameter int N         = 3,
  parameter int RMAX_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            dec_log2,
  input  logic                  in_valid,
  input  logic signed [DSZ-1:0] in_i,
  input  logic signed [DSZ-1:0] in_q,
  output logic                  out_valid,
  output logic signed [DSZ-1:0] out_i,
  output logic signed [DSZ-1:0] out_q
);

  localparam int         ASZ    = DSZ + N * RMAX_LOG2;
  localparam int         CW     = (RMAX_LOG2 > 0) ? RMAX_LOG2 : 1;
  localparam logic [2:0] RMAX_L = 3'(RMAX_LOG2);

  // Remove the CIC gain 2^s. One guard bit keeps the rounding add from
  // wrapping the most positive accumulator value.
  function automatic logic signed [ASZ:0] scale(input logic signed [ASZ-1:0] v,
                                                input int s);
    logic signed [ASZ:0] ext;
    ext = {v[ASZ-1], v};
`ifdef CIC_ROUND_EN
    if (s > 0) ext = ext + ((ASZ+1)'(1) <<< (s - 1));
`endif
    return ext >>> s;
  endfunction

  // Clip to DSZ bits: value fits when all bits above the DSZ sign bit agree.
  function automatic logic signed [DSZ-1:0] sat(input logic signed [ASZ:0] v);
    if ((&v[ASZ:DSZ-1]) || !(|v[ASZ:DSZ-1])) return v[DSZ-1:0];
    return v[ASZ] ? {1'b1, {(DSZ-1){1'b0}}} : {1'b0, {(DSZ-1){1'b1}}};
  endfunction

  logic [2:0]    rate_new;
  logic [2:0]    rate_q;
  logic          flush;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_last;
  int            shift_s;

  logic signed [ASZ-1:0] integ_i_p0 [N];
  logic signed [ASZ-1:0] integ_q_p0 [N];
  logic                  vld_p1;
  logic signed [ASZ-1:0] comb_i_p2 [N];
  logic signed [ASZ-1:0] comb_q_p2 [N];
  logic signed [ASZ-1:0] prev_i_p2 [N];
  logic signed [ASZ-1:0] prev_q_p2 [N];
  logic [N-1:0]          vld_p2;

  assign rate_new = (dec_log2 > RMAX_L) ? RMAX_L : dec_log2;
  assign flush    = (rate_new != rate_q);
  assign cnt_last = CW'((32'd1 << rate_q) - 32'd1);
  assign shift_s  = N * int'(rate_q);

  // rate_q simply tracks the clamped request; a mismatch is the flush cycle,
  // and reset latches the request on the same edge.
  always_ff @(posedge clk) begin
    rate_q <= rate_new;
  end

  // Stage p0: integrators (sample-rate) and decimation counter
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      for (int k = 0; k < N; k++) begin
        integ_i_p0[k] <= '0;
        integ_q_p0[k] <= '0;
      end
      cnt    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid && (cnt == cnt_last);
      if (in_valid) begin
        integ_i_p0[0] <= integ_i_p0[0] + ASZ'(in_i);
        integ_q_p0[0] <= integ_q_p0[0] + ASZ'(in_q);
        for (int k = 1; k < N; k++) begin
          integ_i_p0[k] <= integ_i_p0[k] + integ_i_p0[k-1];
          integ_q_p0[k] <= integ_q_p0[k] + integ_q_p0[k-1];
        end
        cnt <= (cnt == cnt_last) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Stage p1 -> p2: comb chain, each stage advancing on its own valid bit
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      for (int k = 0; k < N; k++) begin
        comb_i_p2[k] <= '0;
        comb_q_p2[k] <= '0;
        prev_i_p2[k] <= '0;
        prev_q_p2[k] <= '0;
      end
      vld_p2 <= '0;
    end else begin
      vld_p2[0] <= vld_p1;
      if (vld_p1) begin
        comb_i_p2[0] <= integ_i_p0[N-1] - prev_i_p2[0];
        comb_q_p2[0] <= integ_q_p0[N-1] - prev_q_p2[0];
        prev_i_p2[0] <= integ_i_p0[N-1];
        prev_q_p2[0] <= integ_q_p0[N-1];
      end
      for (int k = 1; k < N; k++) begin
        vld_p2[k] <= vld_p2[k-1];
        if (vld_p2[k-1]) begin
          comb_i_p2[k] <= comb_i_p2[k-1] - prev_i_p2[k];
          comb_q_p2[k] <= comb_q_p2[k-1] - prev_q_p2[k];
          prev_i_p2[k] <= comb_i_p2[k-1];
          prev_q_p2[k] <= comb_q_p2[k-1];
        end
      end
    end
  end

  // Output stage: gain removal, saturation, register (holds between strobes)
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
    end else begin
      out_valid <= vld_p2[N-1] && !flush;
      if (vld_p2[N-1] && !flush) begin
        out_i <= sat(scale(comb_i_p2[N-1], shift_s));
        out_q <= sat(scale(comb_q_p2[N-1], shift_s));
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Testbench for cic_decimator. Reference model: the CIC is treated as an FIR
// whose impulse response is N convolved length-R boxcars (delayed N-1 input
// samples by the integrator cascade), evaluated at every R-th accepted input,
// then divided by 2^(N*rate) (floor or round half-up) and clipped.
module tb_cic_decimator;
  localparam int DSZ = 16;
  localparam int N = 3;
  localparam int RMAX_LOG2 = 6;
  localparam longint MAXV = (64'sd1 <<< (DSZ-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (DSZ-1));

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] dec_log2 = 3'd0;
  logic in_valid = 1'b0;
  logic signed [DSZ-1:0] in_i = '0;
  logic signed [DSZ-1:0] in_q = '0;
  logic out_valid;
  logic signed [DSZ-1:0] out_i;
  logic signed [DSZ-1:0] out_q;

  cic_decimator #(.DSZ(DSZ), .N(N), .RMAX_LOG2(RMAX_LOG2)) dut (
    .clk(clk), .reset(reset), .dec_log2(dec_log2), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q), .out_valid(out_valid), .out_i(out_i), .out_q(out_q));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;
  int got_c[$], got_i[$], got_q[$];
  int exp_c[$], exp_i[$], exp_q[$];

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      got_c.push_back(cyc);
      got_i.push_back(int'(out_i));
      got_q.push_back(int'(out_q));
    end
  end

  // ---------------- reference model ----------------
  int m_rate = 0;
  longint h[$];
  longint hist_i[$], hist_q[$];

  function automatic int clampr(int d);
    return (d > RMAX_LOG2) ? RMAX_LOG2 : d;
  endfunction

  function automatic void model_restart(int rate, int c);
    longint nh[$];
    longint acc;
    int r;
    r = 1 << rate;
    m_rate = rate;
    hist_i.delete();
    hist_q.delete();
    h.delete();
    h.push_back(1);
    for (int s = 0; s < N; s++) begin
      nh.delete();
      for (int k = 0; k < h.size() + r - 1; k++) begin
        acc = 0;
        for (int j = 0; j < r; j++)
          if (k - j >= 0 && k - j < h.size()) acc += h[k-j];
        nh.push_back(acc);
      end
      h = nh;
    end
    // anything still in flight is discarded
    while (exp_c.size() > 0 && exp_c[exp_c.size()-1] >= c) begin
      void'(exp_c.pop_back());
      void'(exp_i.pop_back());
      void'(exp_q.pop_back());
    end
  endfunction

  function automatic int ref_out(bit ch);
    longint acc;
    int n, idx, s;
    acc = 0;
    n = hist_i.size() - 1;
    s = N * m_rate;
    for (int d = 0; d < h.size(); d++) begin
      idx = n - (N - 1) - d;
      if (idx >= 0) acc += h[d] * (ch ? hist_q[idx] : hist_i[idx]);
    end
`ifdef CIC_ROUND_EN
    if (s > 0) acc += (64'sd1 <<< (s - 1));
`endif
    acc = acc >>> s;
    if (acc > MAXV) acc = MAXV;
    if (acc < MINV) acc = MINV;
    return int'(acc);
  endfunction

  function automatic void model_step(bit rst, bit v, int dec, int xi, int xq, int c);
    if (!rst || clampr(dec) != m_rate) model_restart(clampr(dec), c);
    else if (v) begin
      hist_i.push_back(xi);
      hist_q.push_back(xq);
      if (hist_i.size() % (1 << m_rate) == 0) begin
        exp_c.push_back(c + N + 1);
        exp_i.push_back(ref_out(1'b0));
        exp_q.push_back(ref_out(1'b1));
      end
    end
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(bit rst, bit v, int dec, int xi, int xq);
    reset = rst;
    in_valid = v;
    dec_log2 = 3'(dec);
    in_i = DSZ'(xi);
    in_q = DSZ'(xq);
    @(posedge clk);
    #1;
    model_step(rst, v, dec, xi, xq, cyc);
  endtask

  task automatic start_test(int dec);
    step(1'b0, 1'b0, dec, 0, 0);
    step(1'b0, 1'b0, dec, 0, 0);
    got_c.delete(); got_i.delete(); got_q.delete();
    exp_c.delete(); exp_i.delete(); exp_q.delete();
  endtask

  task automatic drain(int dec);
    repeat (N + 4) step(1'b1, 1'b0, dec, 0, 0);
  endtask

  task automatic test_reset;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 0, 1234, 1234);
      n_cmp++;
      if (out_valid !== 1'b0 || out_i !== 16'sd0 || out_q !== 16'sd0) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: got v=%b i=%0d q=%0d required v=0 i=0 q=0", k, out_valid, out_i, out_q);
      end
    end
    step(1'b1, 1'b1, 0, 1234, 1234);
    n_cmp++;
    if (out_valid !== 1'b0 || out_i !== 16'sd0 || out_q !== 16'sd0) begin
      n_bad++;
      $display("FAIL reset_release: got v=%b i=%0d q=%0d required v=0 i=0 q=0", out_valid, out_i, out_q);
    end
    // reset arriving while samples are in the pipeline
    step(1'b1, 1'b1, 0, 777, -777);
    step(1'b1, 1'b1, 0, 888, -888);
    step(1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0);
    drain(0);
    n_cmp++;
    if (got_c.size() != 0) begin
      n_bad++;
      $display("FAIL reset_midpipe: got %0d out_valid pulses required 0", got_c.size());
    end
  endtask

  task automatic test_decimate;
    start_test(2);
    for (int k = 0; k < 24; k++) begin
      step(1'b1, 1'b1, 2, 1000, -1000);
      repeat (3) step(1'b1, 1'b0, 2, 0, 0);
    end
    drain(2);
    n_cmp++;
    if (got_c.size() != exp_c.size()) begin
      n_bad++;
      $display("FAIL decimate_count: got %0d required %0d", got_c.size(), exp_c.size());
    end
    for (int k = 0; k < got_c.size() && k < exp_c.size(); k++) begin
      n_cmp++;
      if (got_c[k] != exp_c[k] || got_i[k] != exp_i[k] || got_q[k] != exp_q[k]) begin
        n_bad++;
        $display("FAIL decimate_out[%0d]: got cyc%0d %0d/%0d required cyc%0d %0d/%0d", k, got_c[k], got_i[k], got_q[k], exp_c[k], exp_i[k], exp_q[k]);
      end
    end
    for (int k = 1; k < got_c.size(); k++) begin
      n_cmp++;
      if (got_c[k] - got_c[k-1] != 16) begin
        n_bad++;
        $display("FAIL decimate_period[%0d]: got %0d required 16", k, got_c[k] - got_c[k-1]);
      end
    end
    for (int k = 3; k < got_c.size(); k++) begin
      n_cmp++;
      if (got_i[k] != 1000 || got_q[k] != -1000) begin
        n_bad++;
        $display("FAIL decimate_dc[%0d]: got %0d/%0d required 1000/-1000", k, got_i[k], got_q[k]);
      end
    end
  endtask

  task automatic test_ramp;
    int c0;
    start_test(0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b1, 0, k, -k);
      if (k == 0) c0 = cyc;
    end
    drain(0);
    n_cmp++;
    if (got_c.size() != 40) begin
      n_bad++;
      $display("FAIL ramp_count: got %0d required 40", got_c.size());
    end
    if (got_c.size() > 0) begin
      n_cmp++;
      if (got_c[0] != c0 + N + 1) begin
        n_bad++;
        $display("FAIL ramp_latency: got cyc%0d required cyc%0d", got_c[0], c0 + N + 1);
      end
    end
    for (int k = 0; k < got_c.size(); k++) begin
      n_cmp++;
      if (got_i[k] != ((k >= N-1) ? k-(N-1) : 0) || got_q[k] != -((k >= N-1) ? k-(N-1) : 0) ||
          (k > 0 && got_c[k] != got_c[k-1] + 1)) begin
        n_bad++;
        $display("FAIL ramp_out[%0d]: got cyc%0d %0d/%0d required %0d", k, got_c[k], got_i[k], got_q[k], (k >= N-1) ? k-(N-1) : 0);
      end
    end
  endtask

  task automatic test_fullscale(int dec, int xi, int xq, int groups);
    start_test(dec);
    for (int k = 0; k < groups * 64; k++) step(1'b1, 1'b1, dec, xi, xq);
    drain(dec);
    n_cmp++;
    if (got_c.size() != groups) begin
      n_bad++;
      $display("FAIL fullscale%0d_count: got %0d required %0d", dec, got_c.size(), groups);
    end
    for (int k = 0; k < got_c.size() && k < exp_c.size(); k++) begin
      n_cmp++;
      if (got_c[k] != exp_c[k] || got_i[k] != exp_i[k] || got_q[k] != exp_q[k]) begin
        n_bad++;
        $display("FAIL fullscale%0d_out[%0d]: got cyc%0d %0d/%0d required cyc%0d %0d/%0d", dec, k, got_c[k], got_i[k], got_q[k], exp_c[k], exp_i[k], exp_q[k]);
      end
    end
    if (got_c.size() > 2) begin
      n_cmp++;
      if (got_i[got_c.size()-1] != xi || got_q[got_c.size()-1] != xq) begin
        n_bad++;
        $display("FAIL fullscale%0d_settled: got %0d/%0d required %0d/%0d", dec, got_i[got_c.size()-1], got_q[got_c.size()-1], xi, xq);
      end
    end
  endtask

  task automatic test_rate_change;
    int nlast;
    start_test(2);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 2, 500, -500);
    step(1'b1, 1'b1, 3, 500, -500);
    for (int k = 0; k < 48; k++) step(1'b1, 1'b1, 3, 500, -500);
    drain(3);
    // one old-rate output escapes before the flush, the second is discarded
    n_cmp++;
    if (got_c.size() != 7 || got_c.size() != exp_c.size()) begin
      n_bad++;
      $display("FAIL ratechg_count: got %0d required 7 (model %0d)", got_c.size(), exp_c.size());
    end
    for (int k = 0; k < got_c.size() && k < exp_c.size(); k++) begin
      n_cmp++;
      if (got_c[k] != exp_c[k] || got_i[k] != exp_i[k] || got_q[k] != exp_q[k]) begin
        n_bad++;
        $display("FAIL ratechg_out[%0d]: got cyc%0d %0d/%0d required cyc%0d %0d/%0d", k, got_c[k], got_i[k], got_q[k], exp_c[k], exp_i[k], exp_q[k]);
      end
    end
    nlast = got_c.size();
    for (int k = 2; k < nlast; k++) begin
      n_cmp++;
      if (got_c[k] - got_c[k-1] != 8) begin
        n_bad++;
        $display("FAIL ratechg_period[%0d]: got %0d required 8", k, got_c[k] - got_c[k-1]);
      end
    end
    if (nlast > 0) begin
      n_cmp++;
      if (got_i[nlast-1] != 500 || got_q[nlast-1] != -500) begin
        n_bad++;
        $display("FAIL ratechg_settled: got %0d/%0d required 500/-500", got_i[nlast-1], got_q[nlast-1]);
      end
    end
  endtask

  task automatic test_rounding;
    int ei, eq, nlast;
`ifdef CIC_ROUND_EN
    ei = 2; eq = -1;
`else
    ei = 1; eq = -2;
`endif
    start_test(1);
    for (int k = 0; k < 24; k++) step(1'b1, 1'b1, 1, (k % 2) + 1, -((k % 2) + 1));
    drain(1);
    nlast = got_c.size();
    n_cmp++;
    if (nlast != 12) begin
      n_bad++;
      $display("FAIL round_count: got %0d required 12", nlast);
    end
    for (int k = 4; k < nlast; k++) begin
      n_cmp++;
      if (got_i[k] != ei || got_q[k] != eq) begin
        n_bad++;
        $display("FAIL round_out[%0d]: got %0d/%0d required %0d/%0d", k, got_i[k], got_q[k], ei, eq);
      end
    end
  endtask

  task automatic test_random;
    int dec, xi, xq;
    bit v;
    for (int ep = 0; ep < 3; ep++) begin
      dec = $urandom_range(0, 4);
      start_test(dec);
      for (int k = 0; k < 700; k++) begin
        if ($urandom_range(0, 199) == 0) dec = $urandom_range(0, 7);
        v = ($urandom_range(0, 3) != 0);
        xi = int'($urandom_range(0, 65535)) - 32768;
        xq = int'($urandom_range(0, 65535)) - 32768;
        step(1'b1, v, dec, xi, xq);
      end
      drain(dec);
      n_cmp++;
      if (got_c.size() != exp_c.size()) begin
        n_bad++;
        $display("FAIL random%0d_count: got %0d required %0d", ep, got_c.size(), exp_c.size());
      end
      for (int k = 0; k < got_c.size() && k < exp_c.size(); k++) begin
        n_cmp++;
        if (got_c[k] != exp_c[k] || got_i[k] != exp_i[k] || got_q[k] != exp_q[k]) begin
          n_bad++;
          $display("FAIL random%0d_out[%0d]: got cyc%0d %0d/%0d required cyc%0d %0d/%0d", ep, k, got_c[k], got_i[k], got_q[k], exp_c[k], exp_i[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_decimate;
    test_ramp;
    test_fullscale(6, 32767, -32768, 6);
    test_fullscale(7, 12345, -321, 4);
    test_rate_change;
    test_rounding;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
